// File: rtl/iter_div_if.sv
// Operand/result handshake bundle for the iterative divider.
// WIDTH must match the WIDTH of the iter_div instance it is connected to.
interface iter_div_if #(
  parameter int WIDTH = 32
);
  logic             div_signed;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output div_signed, src1, src2, in_valid, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  div_signed, src1, src2, in_valid, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider (one quotient bit per cycle, signed/unsigned per op).
// Optional DIV_EARLY_ZERO_EN: a zero divisor skips the iterations and completes one cycle after acceptance.
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  iter_div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // |dividend|, shifted out MSB-first while quotient bits shift in
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             a_neg, b_neg;
  logic             early_zero;

`ifdef DIV_EARLY_ZERO_EN
  assign early_zero = (dsr_q == '0);
`else
  assign early_zero = 1'b0;
`endif

  // The shifted remainder needs WIDTH+1 bits; the kept result always fits back in WIDTH.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dsr_q};
  assign a_neg     = bus.div_signed & bus.src1[WIDTH-1];
  assign b_neg     = bus.div_signed & bus.src2[WIDTH-1];

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case leaves a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    src1_d      = src1_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          src1_d  = bus.src1;
          dvd_d   = a_neg ? -bus.src1 : bus.src1;
          dsr_d   = b_neg ? -bus.src2 : bus.src2;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == LAST_STEP || early_zero) begin
          if (dsr_q == '0) begin
            quotient_d  = '1;
            remainder_d = src1_q;
            dbz_d       = 1'b1;
          end else begin
            quotient_d  = q_neg_q ? -dvd_q : dvd_q;
            remainder_d = r_neg_q ? -rem_q : rem_q;
            dbz_d       = 1'b0;
          end
          state_d = DONE;
        end else begin
          rem_d = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // NOTE: working registers are always loaded in IDLE before use, so they carry no reset.
  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    dvd_q   <= dvd_d;
    rem_q   <= rem_d;
    dsr_q   <= dsr_d;
    src1_q  <= src1_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
